// File: rtl/rv32i_types_pkg.sv
// Base RV32I scalar types shared across the pipeline and its extensions.
package rv32i_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/rv32m_pkg.sv
// RV32M multiply/divide extension: opcode and FSM types plus division constants.
package rv32m_pkg;

    import rv32i_types_pkg::*;

    // Encoding matches the RV32M funct3 field, so bit 2 marks the divide group.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        DONE
    } muldiv_state_t;

    localparam word_t DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam word_t INT_MIN    = 32'h8000_0000;

    function automatic logic is_div_op(input muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/risc_mgmt_execute_if.sv
// Execute-stage handshake between RISC-MGMT and an extension's execute stage.
interface risc_mgmt_execute_if;

    import rv32i_types_pkg::*;

    word_t rdata_s_0;
    word_t rdata_s_1;
    word_t pc;
    logic  exception;
    logic  busy;
    logic  reg_w;
    word_t reg_wdata;
    logic  branch_jump;
    word_t br_j_addr;

    modport ext (
        input  rdata_s_0, rdata_s_1, pc,
        output exception, busy, reg_w, reg_wdata, branch_jump, br_j_addr
    );

    modport mgmt (
        output rdata_s_0, rdata_s_1, pc,
        input  exception, busy, reg_w, reg_wdata, branch_jump, br_j_addr
    );

endinterface

// File: rtl/muldiv_iter_unit.sv
// Shared 64-bit iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
// The subtract-restore path exists only when RV32M_DIV_EN is defined.
module muldiv_iter_unit
    import rv32i_types_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_mode,
    input  word_t       i_operand,
    input  word_t       i_init_lo,
    output logic [63:0] o_acc,
    output logic        o_last
);

    logic [63:0] r_acc;
    word_t       r_operand;
    logic [5:0]  r_cnt;

    logic [32:0] w_sum;
    logic [63:0] w_acc_mul;
    logic [63:0] w_acc_next;

    // Low half doubles as the multiplier / dividend shift register.
    always_comb begin
        w_sum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);
        w_acc_mul = {w_sum, r_acc[31:1]};
    end

`ifdef RV32M_DIV_EN
    logic [32:0] w_shift_hi;
    logic [33:0] w_diff;
    logic [63:0] w_acc_div;
    logic        w_unused_diff_msb;

    // Partial remainder needs 33 bits after the shift; it fits back in 32 once reduced.
    always_comb begin
        w_shift_hi = r_acc[63:31];
        w_diff     = {1'b0, w_shift_hi} - {2'b00, r_operand};
        w_acc_div  = w_diff[33] ? {r_acc[62:0], 1'b0} : {w_diff[31:0], r_acc[30:0], 1'b1};
        w_acc_next = i_mode ? w_acc_div : w_acc_mul;
    end

    assign w_unused_diff_msb = w_diff[32];
`else
    logic w_unused_mode;

    assign w_unused_mode = i_mode;

    always_comb begin
        w_acc_next = w_acc_mul;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
        end else if (i_load) begin
            r_acc     <= {32'd0, i_init_lo};
            r_operand <= i_operand;
            r_cnt     <= '0;
        end else if (i_step) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == 6'd31);

endmodule

// File: rtl/ext_muldiv_execute.sv
// RISC-MGMT extension execute stage for RV32M on a shared iterative datapath.
// Define RV32M_DIV_EN to build the divider; otherwise divide ops raise an exception.
module ext_muldiv_execute
    import rv32i_types_pkg::*;
    import rv32m_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  muldiv_op_t          op,
    input  logic                flush,
    risc_mgmt_execute_if.ext    exec_if
);

    muldiv_state_t r_state, w_state_d;
    muldiv_op_t    r_op;
    logic          r_neg;
    logic          r_special;
    logic          r_exc;
    word_t         r_result;

    word_t w_rs1, w_rs2, w_mag1, w_mag2, w_special_res, w_iter_operand, w_iter_init;
    logic  w_neg1, w_neg2, w_is_div, w_rem, w_sign, w_special, w_exc_start, w_take;
    logic  w_load, w_step, w_mode, w_last;
    logic [2*XLEN-1:0] w_acc, w_prod;
    word_t w_mul_res, w_calc;
    logic  w_unused_pc;

    assign w_rs1       = exec_if.rdata_s_0;
    assign w_rs2       = exec_if.rdata_s_1;
    assign w_unused_pc = ^exec_if.pc;

    // Start-cycle decode: operand magnitudes, result sign and the short-circuit cases.
    always_comb begin
        w_is_div = is_div_op(op);
        w_rem    = (op == REM) || (op == REMU);
        w_neg1   = (op inside {MULH, MULHSU, DIV, REM}) && w_rs1[31];
        w_neg2   = (op inside {MULH, DIV, REM}) && w_rs2[31];
        w_mag1   = w_neg1 ? (~w_rs1 + 32'd1) : w_rs1;
        w_mag2   = w_neg2 ? (~w_rs2 + 32'd1) : w_rs2;
        w_sign   = w_rem ? w_neg1 : (w_neg1 ^ w_neg2);
        w_take   = (r_state == IDLE) && start && !flush;
        w_iter_operand = w_is_div ? w_mag2 : w_mag1;
        w_iter_init    = w_is_div ? w_mag1 : w_mag2;
`ifdef RV32M_DIV_EN
        w_exc_start = 1'b0;
        if (w_rs2 == '0) begin
            w_special     = w_is_div;
            w_special_res = w_rem ? w_rs1 : DIV_ZERO_Q;
        end else if ((op == DIV || op == REM) && w_rs1 == INT_MIN && w_rs2 == '1) begin
            w_special     = 1'b1;
            w_special_res = w_rem ? '0 : INT_MIN;
        end else begin
            w_special     = 1'b0;
            w_special_res = '0;
        end
`else
        w_exc_start   = w_is_div;
        w_special     = 1'b0;
        w_special_res = '0;
`endif
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_mode    = (r_state == DIV_RUN);
        unique case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_load = 1'b1;
                    if (w_special || w_exc_start) begin
                        w_state_d = DONE;
                    end else begin
                        w_state_d = w_is_div ? DIV_RUN : MUL_RUN;
                    end
                end
            end
            MUL_RUN, DIV_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_d = DONE;
                end
            end
            DONE: w_state_d = IDLE;
        endcase
        if (flush) begin
            w_state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_op      <= MUL;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_exc     <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_take) begin
                r_op      <= op;
                r_neg     <= w_sign;
                r_special <= w_special;
                r_exc     <= w_exc_start;
                r_result  <= w_special_res;
            end
        end
    end

    muldiv_iter_unit u_iter (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_mode    (w_mode),
        .i_operand (w_iter_operand),
        .i_init_lo (w_iter_init),
        .o_acc     (w_acc),
        .o_last    (w_last)
    );

    // Result is formed from the held accumulator while in DONE.
    always_comb begin
        w_prod    = r_neg ? (~w_acc + 64'd1) : w_acc;
        w_mul_res = (r_op == MUL) ? w_prod[31:0] : w_prod[63:32];
`ifdef RV32M_DIV_EN
        begin
            word_t w_div_mag;
            w_div_mag = (r_op == REM || r_op == REMU) ? w_acc[63:32] : w_acc[31:0];
            w_calc    = r_op[2] ? (r_neg ? (~w_div_mag + 32'd1) : w_div_mag) : w_mul_res;
        end
`else
        w_calc = w_mul_res;
`endif
    end

    assign exec_if.busy        = w_take || (r_state == MUL_RUN) || (r_state == DIV_RUN);
    assign exec_if.reg_w       = (r_state == DONE) && !r_exc;
    assign exec_if.exception   = (r_state == DONE) && r_exc;
    assign exec_if.reg_wdata   = ((r_state == DONE) && !r_exc) ?
                                 (r_special ? r_result : w_calc) : '0;
    assign exec_if.branch_jump = 1'b0;
    assign exec_if.br_j_addr   = '0;

endmodule

// File: tb/tb_ext_muldiv_execute.sv
// Self-checking bench for ext_muldiv_execute: directed plan cases, aborts and random ops.
module tb_ext_muldiv_execute;

    import rv32i_types_pkg::*;
    import rv32m_pkg::*;

`ifdef RV32M_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       flush;
    muldiv_op_t op;
    int         checks = 0;
    int         errors = 0;

    risc_mgmt_execute_if ifc ();

    ext_muldiv_execute #(.XLEN(32)) dut (
        .CLK     (clk),
        .RST     (rst),
        .start   (start),
        .op      (op),
        .flush   (flush),
        .exec_if (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference semantics from the RV32M rules with plain 64-bit arithmetic.
    function automatic word_t ref_result(input muldiv_op_t o, input word_t a, input word_t b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p;
        case (o)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input muldiv_op_t o, input word_t a, input word_t b);
        if (o inside {DIV, DIVU, REM, REMU}) begin
            if (!DivEn || b == 0) return 1;
            if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        end
        return 33;
    endfunction

    function automatic word_t pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at cycle 0; optionally re-pulse start at poke cycle (must be ignored).
    task automatic run_op(input string tag, input muldiv_op_t o, input word_t a, input word_t b,
                          input word_t exp_val, input int poke);
        int lat      = ref_latency(o, a, b);
        bit exc      = DivEn ? 1'b0 : (o inside {DIV, DIVU, REM, REMU});
        int done_cyc = -1;
        int busy_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; ifc.rdata_s_0 = a; ifc.rdata_s_1 = b;
        #1;
        if (ifc.busy) busy_cnt++;
        @(posedge clk); #1;
        ifc.rdata_s_0 = $urandom;
        ifc.rdata_s_1 = $urandom;
        for (int c = 1; c <= 40; c++) begin
            start = (c == poke);
            op    = (c == poke) ? DIVU : o;
            #1;
            if (ifc.reg_w || ifc.exception) begin
                done_cyc = c;
                break;
            end
            if (ifc.busy) busy_cnt++;
            @(posedge clk); #1;
        end
        check({tag, " done_cycle"}, done_cyc, lat);
        check({tag, " busy_cycles"}, busy_cnt, lat);
        if (done_cyc > 0) begin
            check({tag, " exception"}, {31'd0, ifc.exception}, {31'd0, exc});
            check({tag, " reg_w"}, {31'd0, ifc.reg_w}, {31'd0, !exc});
            check({tag, " busy_in_done"}, {31'd0, ifc.busy}, 32'd0);
            if (!exc) check({tag, " reg_wdata"}, ifc.reg_wdata, exp_val);
        end
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check({tag, " reg_w_after"}, {31'd0, ifc.reg_w}, 32'd0);
        check({tag, " busy_after"}, {31'd0, ifc.busy}, 32'd0);
    endtask

    // Abort a MUL at cycle at_cyc via flush or RST, then expect silence.
    task automatic abort_op(input string tag, input bit use_rst, input int at_cyc);
        int pulses = 0;
        @(posedge clk); #1;
        start = 1'b1; op = MUL; ifc.rdata_s_0 = 32'd9; ifc.rdata_s_1 = 32'd11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (at_cyc - 1) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        #1;
        check({tag, " busy_after_abort"}, {31'd0, ifc.busy}, 32'd0);
        check({tag, " reg_wdata_after_abort"}, ifc.reg_wdata, 32'd0);
        for (int c = 0; c < 40; c++) begin
            if (ifc.reg_w || ifc.busy) pulses++;
            @(posedge clk); #2;
        end
        check({tag, " activity_after_abort"}, pulses, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = MUL;
        ifc.rdata_s_0 = '0; ifc.rdata_s_1 = '0; ifc.pc = 32'h0000_1000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst busy", {31'd0, ifc.busy}, 32'd0);
        check("rst reg_w", {31'd0, ifc.reg_w}, 32'd0);
        check("rst exception", {31'd0, ifc.exception}, 32'd0);
        check("rst branch_jump", {31'd0, ifc.branch_jump}, 32'd0);
        check("rst reg_wdata", ifc.reg_wdata, 32'd0);
        check("rst br_j_addr", ifc.br_j_addr, 32'd0);

        run_op("mul_7x-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("mulhsu_-1x2", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("mul_3x4", MUL, 32'd3, 32'd4, 32'd12, 0);
        run_op("div_-7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("rem_-7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("divu_5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run_op("div_10/2", DIV, 32'd10, 32'd2, 32'd5, 0);
        run_op("mulh_poke_run", MULH, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 5);
        run_op("mul_poke_done", MUL, 32'd6, 32'd7, 32'd42, 33);

        abort_op("flush_c10", 1'b0, 10);
        abort_op("rst_c20", 1'b1, 20);

        // Flush wins over a simultaneous start.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = MUL; ifc.rdata_s_0 = 32'd2; ifc.rdata_s_1 = 32'd2;
        #1;
        check("flush_start busy", {31'd0, ifc.busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                #1;
                if (ifc.reg_w || ifc.busy) seen++;
                @(posedge clk); #1;
            end
            check("flush_start activity", seen, 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            muldiv_op_t ro;
            word_t      ra, rb;
            ro = muldiv_op_t'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rand%0d_%s", i, ro.name()), ro, ra, rb, ref_result(ro, ra, rb), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
